// File: rtl/axis_sequence_checker.sv
// AXI-Stream sink that checks the 1..N counting sequence and the tlast position.
// Optional define AXIS_SEQ_CHECKER_STALL_EN adds LFSR-driven backpressure on s_axis_tready.
module axis_sequence_checker #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  i_enable,
  input  logic [31:0]           i_n_value,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [15:0]           o_err_count,
  output logic [31:0]           o_first_err_idx,
  output logic [31:0]           o_beat_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] n_q, n_d;
  logic [31:0] idx_q, idx_d;
  logic [15:0] err_q, err_d;
  logic [31:0] first_q, first_d;
  logic [31:0] beats_q, beats_d;
  logic        ready_q, ready_d;

  logic                  beat_ok;
  logic                  is_final_idx;
  logic                  beat_bad;
  logic [DATA_WIDTH-1:0] exp_data;

`ifdef AXIS_SEQ_CHECKER_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
`endif

  assign exp_data     = DATA_WIDTH'(idx_q);
  assign beat_ok      = (state_q == ST_RUN) && s_axis_tvalid && ready_q;
  assign is_final_idx = (idx_q == n_q);
  // Data and tlast mismatches on the same beat count as a single error.
  assign beat_bad     = (s_axis_tdata != exp_data) || (s_axis_tlast != is_final_idx);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    err_d   = err_q;
    first_d = first_q;
    beats_d = beats_q;
`ifdef AXIS_SEQ_CHECKER_STALL_EN
    lfsr_d  = lfsr_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_enable) begin
          n_d     = i_n_value;
          idx_d   = 32'd1;
          err_d   = 16'd0;
          first_d = 32'd0;
          beats_d = 32'd0;
          state_d = (i_n_value == 32'd0) ? ST_DONE : ST_RUN;
`ifdef AXIS_SEQ_CHECKER_STALL_EN
          lfsr_d  = 16'hACE1;
`endif
        end
      end
      ST_RUN: begin
`ifdef AXIS_SEQ_CHECKER_STALL_EN
        lfsr_d = {lfsr_q[14:0], lfsr_fb};
`endif
        if (beat_ok) begin
          beats_d = beats_q + 32'd1;
          idx_d   = idx_q + 32'd1;
          if (beat_bad) begin
            if (err_q != 16'hFFFF) begin
              err_d = err_q + 16'd1;
            end
            if (first_q == 32'd0) begin
              first_d = idx_q;
            end
          end
          if (s_axis_tlast || is_final_idx) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is registered, so it is derived from the next state rather than the current one.
`ifdef AXIS_SEQ_CHECKER_STALL_EN
  assign ready_d = (state_d == ST_RUN) && lfsr_d[0];
`else
  assign ready_d = (state_d == ST_RUN);
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      n_q     <= 32'd0;
      idx_q   <= 32'd0;
      err_q   <= 16'd0;
      first_q <= 32'd0;
      beats_q <= 32'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      first_q <= first_d;
      beats_q <= beats_d;
      ready_q <= ready_d;
    end
  end

`ifdef AXIS_SEQ_CHECKER_STALL_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`endif

  assign s_axis_tready   = ready_q;
  assign o_busy          = (state_q == ST_RUN);
  assign o_done          = (state_q == ST_DONE);
  assign o_pass          = (state_q == ST_DONE) && (err_q == 16'd0);
  assign o_err_count     = err_q;
  assign o_first_err_idx = first_q;
  assign o_beat_count    = beats_q;

endmodule
